// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller and the divider.
// Contents: divide FSM state encoding and default divide timing parameters.
package hazard_stall_ctrl_pkg;

  localparam int unsigned DEFAULT_DIV_CYCLES = 32;
  localparam int unsigned DEFAULT_CNT_W      = 6;
  localparam int unsigned REG_W              = 5;
  localparam int unsigned STALL_CNT_W        = 32;

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard detect between the ID instruction and a load in EX.
// Ports:
//   id_rs, id_rt   source register fields of the instruction in ID
//   id_uses_rt     ID instruction reads rt
//   ex_rt          destination (rt) of the instruction in ID/EX
//   ex_memRead     instruction in ID/EX is a load
//   load_use_c     hazard present (combinational)
module load_use_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_memRead,
  output logic             load_use_c
);

  // A load into $zero never creates a dependency.
  always_comb begin
    load_use_c = ex_memRead && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for PC, IF/ID and ID/EX: divide freeze,
// taken-branch flush and load-use bubble, plus a stall-cycle counter.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt      ID-stage source operands
//   ex_rt, ex_memRead, ex_divd    ID/EX-stage destination, load and divide flags
//   ex_branch_tkn                 branch in EX resolved taken
//   pc_enable, if_id_enable,
//   id_ex_enable                  register write enables (combinational)
//   if_id_flush, id_ex_flush      flush/bubble controls (combinational)
//   div_start, div_busy           divider start pulse / freeze in progress
//   stall_count                   cycles with pc_enable == 0
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DEFAULT_DIV_CYCLES,
  parameter int unsigned CNT_W      = DEFAULT_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_W-1:0]       id_rs,
  input  logic [REG_W-1:0]       id_rt,
  input  logic                   id_uses_rt,
  input  logic [REG_W-1:0]       ex_rt,
  input  logic                   ex_memRead,
  input  logic                   ex_divd,
  input  logic                   ex_branch_tkn,
  output logic                   pc_enable,
  output logic                   if_id_enable,
  output logic                   id_ex_enable,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   div_start,
  output logic                   div_busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  div_state_e             state;
  div_state_e             state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   load_use;
  logic                   div_detect;
  logic                   div_freeze;

  load_use_detect u_load_use_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_rt      (ex_rt),
    .ex_memRead (ex_memRead),
    .load_use_c (load_use)
  );

  // A divide is only recognised from IDLE, so the release cycle cannot retrigger.
  always_comb begin
    div_detect = (state == IDLE) && ex_divd;
    div_freeze = div_detect || ((state == DIV_BUSY) && (cnt != '0));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (ex_divd)    state_nxt = DIV_BUSY;
      DIV_BUSY: if (cnt == '0)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Output logic: divide freeze > taken branch > load-use > normal flow.
  always_comb begin
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    id_ex_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    div_start    = 1'b0;
    div_busy     = 1'b0;
    if (!rst) begin
      if (div_freeze) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_enable = 1'b0;
        div_start    = div_detect;
        div_busy     = 1'b1;
      end else if (ex_branch_tkn) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (load_use) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // Divide countdown: loaded on detect, runs down to the release cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (div_detect) begin
      cnt <= CNT_W'(DIV_CYCLES - 1);
    end else if ((state == DIV_BUSY) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Stall-cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_enable) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios with literal
// expectations, followed by randomized traffic checked against a cycle model.
module tb_hazard_stall_ctrl;

  localparam int unsigned DC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memRead, ex_divd, ex_branch_tkn;
  logic        pc_enable, if_id_enable, id_ex_enable;
  logic        if_id_flush, id_ex_flush, div_start, div_busy;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;

  hazard_stall_ctrl #(.DIV_CYCLES(DC), .CNT_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_rt         (ex_rt),
    .ex_memRead    (ex_memRead),
    .ex_divd       (ex_divd),
    .ex_branch_tkn (ex_branch_tkn),
    .pc_enable     (pc_enable),
    .if_id_enable  (if_id_enable),
    .id_ex_enable  (id_ex_enable),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .div_start     (div_start),
    .div_busy      (div_busy),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: remaining freeze cycles after the detect cycle,
  // a release flag, and the expected stall count.
  int          m_left    = 0;
  bit          m_release = 1'b0;
  logic [31:0] m_cnt     = '0;

  always @(negedge clk) begin
    logic       lu, frz;
    logic [6:0] e;   // {pc, ifid, idex, iff, idf, start, busy}
    lu = ex_memRead && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    e   = 7'b111_0000;
    frz = 1'b0;
    if (!rst) begin
      frz = (m_left > 0) || (!m_release && ex_divd);
      if (frz)                e = {3'b000, 2'b00, (m_left == 0), 1'b1};
      else if (ex_branch_tkn) e = 7'b111_1100;
      else if (lu)            e = 7'b001_0100;
    end
    chk("ctrl", 32'({pc_enable, if_id_enable, id_ex_enable, if_id_flush,
                     id_ex_flush, div_start, div_busy}), 32'(e));
    chk("stall_count", stall_count, m_cnt);
    if (rst) begin
      m_left = 0; m_release = 1'b0; m_cnt = '0;
    end else begin
      if (!e[6]) m_cnt = m_cnt + 32'd1;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_release = 1'b1;
      end else if (m_release) begin
        m_release = 1'b0;
      end else if (ex_divd) begin
        m_left = int'(DC) - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rt = 5'd0;
    ex_memRead = 1'b0; ex_divd = 1'b0; ex_branch_tkn = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    tick(); tick();
    #1;
    chk("rst_pc_enable", 32'(pc_enable), 32'd1);
    chk("rst_flush", 32'({if_id_flush, id_ex_flush}), 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);

    // Load-use on r8
    tick(); rst = 1'b0;
    ex_memRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    chk("lu_pc_enable", 32'(pc_enable), 32'd0);
    chk("lu_if_id_enable", 32'(if_id_enable), 32'd0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    tick(); idle_in(); #1;
    chk("lu_stall_count", stall_count, 32'd1);
    chk("lu_done_pc", 32'(pc_enable), 32'd1);

    // $zero never hazards
    tick(); ex_memRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
    chk("zero_pc_enable", 32'(pc_enable), 32'd1);
    chk("zero_flush", 32'(id_ex_flush), 32'd0);

    // Single divide held until release
    tick(); idle_in(); ex_divd = 1'b1; #1;
    chk("div_start", 32'(div_start), 32'd1);
    chk("div_freeze0", 32'({pc_enable, if_id_enable, id_ex_enable}), 32'd0);
    for (int i = 1; i < int'(DC); i++) begin
      tick(); #1;
      chk("div_freeze", 32'({pc_enable, id_ex_enable, div_start, div_busy}), 32'b0001);
    end
    tick(); #1;
    chk("div_release", 32'({pc_enable, if_id_enable, id_ex_enable, div_start, div_busy}), 32'b11100);
    tick(); ex_divd = 1'b0; #1;
    chk("div_no_retrigger", 32'(pc_enable), 32'd1);
    chk("div_stall_count", stall_count, 32'd5);

    // Branch beats load-use
    tick(); ex_branch_tkn = 1'b1; ex_memRead = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; #1;
    chk("br_flush", 32'({if_id_flush, id_ex_flush}), 32'b11);
    chk("br_enables", 32'({pc_enable, if_id_enable, id_ex_enable}), 32'b111);
    tick(); idle_in(); #1;
    chk("br_stall_count", stall_count, 32'd5);

    // Back-to-back divides
    tick(); ex_divd = 1'b1; #1;
    for (int i = 0; i < 2 * (int'(DC) + 1); i++) begin
      if (i == int'(DC) || i == 2 * int'(DC) + 1)
        chk("b2b_release", 32'({pc_enable, div_start}), 32'b10);
      else if (i == 0 || i == int'(DC) + 1)
        chk("b2b_start", 32'({pc_enable, div_start}), 32'b01);
      else
        chk("b2b_freeze", 32'({pc_enable, div_start}), 32'b00);
      tick(); #1;
    end
    ex_divd = 1'b0; #1;
    chk("b2b_stall_count", stall_count, 32'd13);

    // Reset during a divide
    tick(); ex_divd = 1'b1;
    tick(); rst = 1'b1; #1;
    chk("rst_mid_outputs", 32'({pc_enable, if_id_enable, id_ex_enable, div_start, div_busy}), 32'b11100);
    tick(); rst = 1'b0; ex_divd = 1'b0; #1;
    chk("rst_mid_stall", stall_count, 32'd0);
    chk("rst_mid_idle", 32'({pc_enable, div_busy}), 32'b10);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst           = ($urandom_range(0, 199) == 0);
      ex_divd       = ($urandom_range(0, 7) == 0);
      ex_branch_tkn = ($urandom_range(0, 4) == 0);
      ex_memRead    = $urandom_range(0, 1) == 1;
      id_uses_rt    = $urandom_range(0, 1) == 1;
      ex_rt         = 5'($urandom_range(0, 3));
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
    end
    tick(); idle_in(); rst = 1'b0;
    tick();
    #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
